// File: rtl/prog3_search_engine.sv
// Program-3 pattern-search responder: reads a 32-byte message and a 5-bit pattern, writes three match counts.
// Define PROG3_CYCCNT_EN to add a cycle counter written to RES_ADDR+3 (one extra write state).
module prog3_search_engine #(
   parameter int MSG_BYTES = 32,
   parameter int PAT_ADDR  = 32,
   parameter int RES_ADDR  = 33
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Req,
   output logic       Ack,
   output logic [7:0] Addr,
   input  logic [7:0] RdData,
   output logic       WrEn,
   output logic [7:0] WrData
);

   localparam logic [5:0] LAST_IDX  = 6'(MSG_BYTES - 1);
   localparam logic [5:0] DRAIN_CAP = 6'(MSG_BYTES);
   localparam logic [5:0] DRAIN_END = 6'(MSG_BYTES + 1);
   localparam logic [7:0] PAT_A     = 8'(PAT_ADDR);
   localparam logic [7:0] RES_A0    = 8'(RES_ADDR);
   localparam logic [7:0] RES_A1    = 8'(RES_ADDR + 1);
   localparam logic [7:0] RES_A2    = 8'(RES_ADDR + 2);
   localparam logic [7:0] RES_A3    = 8'(RES_ADDR + 3);

   typedef enum logic [3:0] {
      IDLE, RDPAT, SCAN, DRAIN, WR0, WR1, WR2, WR3, DONE
   } state_t;

   state_t     state, state_next;
   logic [5:0] idx;
   logic [4:0] pat;
   logic [7:0] byte_q;
   logic       byte_vld;
   logic       first;
   logic [3:0] prev;
   logic [7:0] ctb, cto, cts;
   logic       start;
   logic [3:0] in_hit, cross_hit;
   logic [2:0] in_cnt, cross_cnt;
   logic [11:0] win;
`ifdef PROG3_CYCCNT_EN
   logic [7:0] cyc_cnt;
`endif

   assign start = Req && (state == IDLE || state == DONE);
   assign win   = {prev, byte_q};

   // hit[gi]: in-byte window byte_q[gi+4:gi]; crossing window win[gi+8:gi+4] starts inside prev
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_win
         assign in_hit[gi]    = (byte_q[gi +: 5] == pat);
         assign cross_hit[gi] = (win[gi + 4 +: 5] == pat);
      end
   endgenerate

   assign in_cnt    = {2'b0, in_hit[0]} + {2'b0, in_hit[1]} + {2'b0, in_hit[2]} + {2'b0, in_hit[3]};
   assign cross_cnt = {2'b0, cross_hit[0]} + {2'b0, cross_hit[1]}
                    + {2'b0, cross_hit[2]} + {2'b0, cross_hit[3]};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      Ack        = 1'b0;
      WrEn       = 1'b0;
      Addr       = 8'd0;
      WrData     = 8'd0;
      case (state)
         IDLE:  if (Req) state_next = RDPAT;
         RDPAT: begin
            Addr       = PAT_A;
            state_next = SCAN;
         end
         SCAN: begin
            Addr = 8'(idx);
            if (idx == LAST_IDX) state_next = DRAIN;
         end
         DRAIN: if (idx == DRAIN_END) state_next = WR0;
         WR0: begin
            WrEn = 1'b1; Addr = RES_A0; WrData = ctb;
            state_next = WR1;
         end
         WR1: begin
            WrEn = 1'b1; Addr = RES_A1; WrData = cto;
            state_next = WR2;
         end
         WR2: begin
            WrEn = 1'b1; Addr = RES_A2; WrData = cts;
`ifdef PROG3_CYCCNT_EN
            state_next = WR3;
`else
            state_next = DONE;
`endif
         end
`ifdef PROG3_CYCCNT_EN
         WR3: begin
            WrEn = 1'b1; Addr = RES_A3; WrData = cyc_cnt;
            state_next = DONE;
         end
`endif
         DONE: begin
            Ack = 1'b1;
            if (Req) begin
               Ack        = 1'b0;
               state_next = RDPAT;
            end
         end
         default: state_next = IDLE;
      endcase
      // Ack is a state flag; a Req in DONE takes effect only at the edge
      if (state == DONE) Ack = 1'b1;
   end

   // Read data lags Addr by one cycle: SCAN idx 0 sees the pattern, idx k sees byte k-1,
   // and DRAIN picks up the last byte; counting happens one cycle after capture.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         idx      <= 6'd0;
         pat      <= 5'd0;
         byte_q   <= 8'd0;
         byte_vld <= 1'b0;
         first    <= 1'b1;
         prev     <= 4'd0;
         ctb      <= 8'd0;
         cto      <= 8'd0;
         cts      <= 8'd0;
      end else if (start) begin
         idx      <= 6'd0;
         byte_vld <= 1'b0;
         first    <= 1'b1;
         prev     <= 4'd0;
         ctb      <= 8'd0;
         cto      <= 8'd0;
         cts      <= 8'd0;
      end else begin
         if (state == SCAN || state == DRAIN) idx <= idx + 6'd1;
         if (state == SCAN && idx == 6'd0) pat <= RdData[7:3];
         if ((state == SCAN && idx != 6'd0) || (state == DRAIN && idx == DRAIN_CAP)) begin
            byte_q   <= RdData;
            byte_vld <= 1'b1;
         end else begin
            byte_vld <= 1'b0;
         end
         if (byte_vld) begin
            ctb   <= ctb + {5'b0, in_cnt};
            cto   <= cto + {7'b0, |in_hit};
            cts   <= cts + {5'b0, in_cnt} + (first ? 8'd0 : {5'b0, cross_cnt});
            prev  <= byte_q[3:0];
            first <= 1'b0;
         end
      end
   end

`ifdef PROG3_CYCCNT_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)                              cyc_cnt <= 8'd0;
      else if (start)                          cyc_cnt <= 8'd0;
      else if (state != IDLE && state != DONE) cyc_cnt <= cyc_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_prog3_search_engine.sv
// Bench for prog3_search_engine: directed and random runs against a bit-string match model.
module tb_prog3_search_engine;

   localparam int PAT = 32;
   localparam int RES = 33;
   localparam int WR_FIRST = 35;
`ifdef PROG3_CYCCNT_EN
   localparam int LAT = 39;
   localparam int NWR = 4;
`else
   localparam int LAT = 38;
   localparam int NWR = 3;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0;
   logic       ack;
   logic [7:0] addr;
   logic [7:0] rd_data;
   logic       wr_en;
   logic [7:0] wr_data;

   logic [7:0] mem [0:255];
   int         checks = 0;
   int         errors = 0;
   int         cyc = -1;        // edges since the accepted Req, -1 when idle or reset
   logic [23:0] exp_pack = 24'd0;

   prog3_search_engine #(.MSG_BYTES(32), .PAT_ADDR(PAT), .RES_ADDR(RES)) dut (
      .Clk(clk), .Reset(rst_n), .Req(req), .Ack(ack), .Addr(addr),
      .RdData(rd_data), .WrEn(wr_en), .WrData(wr_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rd_data <= mem[addr];
      if (wr_en) mem[addr] <= wr_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d cyc=%0d t=%0t", name, act, exp, cyc, $time);
      end
   endtask

   // Counts straight from the 256-bit message string
   function automatic logic [23:0] model_results();
      logic [255:0] s;
      logic [4:0]   p;
      int b, o, t;
      logic hit;
      b = 0; o = 0; t = 0;
      p = mem[PAT][7:3];
      for (int i = 0; i < 32; i++) begin
         s[255 - 8*i -: 8] = mem[i];
         hit = 1'b0;
         for (int sh = 0; sh < 4; sh++)
            if (mem[i][sh +: 5] == p) begin
               b++;
               hit = 1'b1;
            end
         if (hit) o++;
      end
      for (int pos = 0; pos < 252; pos++)
         if (s[255 - pos -: 5] == p) t++;
      return {8'(b), 8'(o), 8'(t)};
   endfunction

   // A run starts whenever Req is seen while idle or done, and lasts LAT cycles
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= -1;
      else if (req && (cyc < 0 || cyc >= LAT)) begin
         cyc      <= 0;
         exp_pack <= model_results();
      end else if (cyc >= 0 && cyc < LAT) cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("ack", ack, (cyc >= LAT) ? 1 : 0);
         chk("wr_en", wr_en, (cyc >= WR_FIRST && cyc < WR_FIRST + NWR) ? 1 : 0);
         if (cyc == 0) chk("addr_pat", addr, PAT);
         if (cyc >= 1 && cyc <= 32) chk("addr_msg", addr, cyc - 1);
         if (cyc >= WR_FIRST && cyc < WR_FIRST + NWR) begin
            chk("addr_wr", addr, RES + cyc - WR_FIRST);
            case (cyc - WR_FIRST)
               0: chk("wr_ctb", wr_data, exp_pack[23:16]);
               1: chk("wr_cto", wr_data, exp_pack[15:8]);
               2: chk("wr_cts", wr_data, exp_pack[7:0]);
               default: chk("wr_cyc", wr_data, 38);
            endcase
         end
      end
   end

   task automatic start_run();
      @(posedge clk); #1 req = 1'b1;
      @(posedge clk); #1 req = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (ack) seen = 1'b1;
      end
      chk("done_timeout", seen, 1);
      @(posedge clk); #1;
   endtask

   task automatic check_mem(input string tag, input logic [23:0] exp);
      chk("mem_ctb", mem[RES], exp[23:16]);
      chk("mem_cto", mem[RES+1], exp[15:8]);
      chk("mem_cts", mem[RES+2], exp[7:0]);
`ifdef PROG3_CYCCNT_EN
      chk("mem_cyc", mem[RES+3], 38);
`else
      chk("mem_res3_untouched", mem[RES+3], 8'hA5);
`endif
      $display("run %s: ctb=%0d cto=%0d cts=%0d", tag, mem[RES], mem[RES+1], mem[RES+2]);
   endtask

   task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] rest,
                       input logic [7:0] pb);
      mem[0] = b0;
      mem[1] = b1;
      for (int i = 2; i < 32; i++) mem[i] = rest;
      mem[PAT] = pb;
   endtask

   task automatic load_random();
      int j, sh;
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      j  = $urandom_range(0, 31);
      sh = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) mem[PAT] = 8'($urandom);
      else mem[PAT] = {mem[j][sh +: 5], 3'($urandom)};
   endtask

   task automatic directed(input string tag, input logic [23:0] lit);
      chk("model_pin", model_results(), lit);
      start_run();
      wait_done();
      check_mem(tag, lit);
   endtask

   initial begin
      logic [23:0] snap, e;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[RES+3] = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_addr", addr, 0);
      chk("rst_wr_data", wr_data, 0);
      rst_n = 1'b1;

      load(8'h00, 8'h00, 8'h00, 8'h00);
      directed("zeros", {8'd128, 8'd32, 8'd252});
      load(8'h55, 8'h55, 8'h55, 8'hA8);
      directed("alt55", {8'd64, 8'd32, 8'd126});
      load(8'hF8, 8'h00, 8'h00, 8'hF8);
      directed("f8_first", {8'd1, 8'd1, 8'd1});
      load(8'h03, 8'hE0, 8'h00, 8'hF8);
      directed("boundary", {8'd0, 8'd0, 8'd1});

      // reset at edge 10 aborts cleanly, then a fresh run completes
      load_random();
      snap = {mem[RES], mem[RES+1], mem[RES+2]};
      start_run();
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_ack", ack, 0);
      chk("abort_wr_en", wr_en, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      chk("abort_mem_kept", {mem[RES], mem[RES+1], mem[RES+2]}, snap);
      e = model_results();
      start_run();
      wait_done();
      check_mem("after_reset", e);

      // extra Req at edge 20 is ignored
      load_random();
      e = model_results();
      start_run();
      repeat (18) @(posedge clk);
      #1 req = 1'b1;
      @(posedge clk); #1 req = 1'b0;
      wait_done();
      check_mem("req_at_20", e);

      // Req in DONE restarts; Req held for several cycles starts one run
      repeat (3) @(posedge clk);
      load_random();
      e = model_results();
      @(posedge clk); #1 req = 1'b1;
      repeat (3) @(posedge clk);
      #1 req = 1'b0;
      wait_done();
      check_mem("held_req", e);

      for (int r = 0; r < 12; r++) begin
         load_random();
         e = model_results();
         start_run();
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 30)) @(posedge clk);
            #1 req = 1'b1;
            @(posedge clk); #1 req = 1'b0;
         end
         wait_done();
         check_mem($sformatf("rand%0d", r), e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
